// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths, requester ids and result record for the normalizer arbiter
package fpu_pkg;

    localparam int EXP_W      = 8;
    localparam int RAW_MANT_W = 48;
    localparam int MANT_W     = 23;
    localparam int OP_W       = 2;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // One buffered result: which requester it belongs to plus the normalized value
    typedef struct packed {
        logic              id;
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - synchronous result FIFO with occupancy count
module fpu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    // An empty FIFO presents zeros rather than stale storage
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array carries no reset; validity is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_normalize_arbiter.sv
// rtl/fpu_normalize_arbiter.sv - round-robin sharing of one normalizer between two requesters
module fpu_normalize_arbiter
    import fpu_pkg::*;
#(
    parameter int NORM_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_sign,
    input  logic [EXP_W-1:0]      a_exponent,
    input  logic [RAW_MANT_W-1:0] a_mantissa,
    input  logic [OP_W-1:0]       a_operator,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_sign,
    input  logic [EXP_W-1:0]      b_exponent,
    input  logic [RAW_MANT_W-1:0] b_mantissa,
    input  logic [OP_W-1:0]       b_operator,

    output logic                  n_in_sign,
    output logic [EXP_W-1:0]      n_in_exponent,
    output logic [RAW_MANT_W-1:0] n_in_mantissa,
    output logic [OP_W-1:0]       n_in_operator,
    input  logic                  n_sign,
    input  logic [EXP_W-1:0]      n_exponent,
    input  logic [MANT_W-1:0]     n_mantissa,

    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic                  res_sign,
    output logic [EXP_W-1:0]      res_exponent,
    output logic [MANT_W-1:0]     res_mantissa,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             last_grant_q;
    logic             tag_vld_q [NORM_LATENCY];
    logic             tag_id_q  [NORM_LATENCY];
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;

    logic             grant_a;
    logic             grant_b;
    logic             xfer;
    logic             xfer_id;
    logic             tag_exit;
    logic [CNT_W:0]   credits_used;
    logic             issue_ok;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    result_t          push_data;
    result_t          head;

    // Every issued op reserves a FIFO slot, so the normalizer never needs a stall
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign issue_ok     = credits_used < (CNT_W + 1)'(FIFO_DEPTH);

    // Round-robin grant: a lone requester wins, contention goes opposite last_grant
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && issue_ok) begin
            if (a_valid && b_valid) begin
                if (last_grant_q == ID_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign xfer    = grant_a || grant_b;
    assign xfer_id = grant_b ? ID_B : ID_A;

    // Normalizer input mux; zeros when nothing is granted
    always_comb begin
        n_in_sign     = 1'b0;
        n_in_exponent = '0;
        n_in_mantissa = '0;
        n_in_operator = '0;
        if (grant_a) begin
            n_in_sign     = a_sign;
            n_in_exponent = a_exponent;
            n_in_mantissa = a_mantissa;
            n_in_operator = a_operator;
        end else if (grant_b) begin
            n_in_sign     = b_sign;
            n_in_exponent = b_exponent;
            n_in_mantissa = b_mantissa;
            n_in_operator = b_operator;
        end
    end

    // Remember the last winner only when a transfer actually happens
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_B;
        end else if (xfer) begin
            last_grant_q <= xfer_id;
        end
    end

    // Tag pipeline mirrors the normalizer latency so each result knows its owner
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NORM_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= ID_A;
            end
        end else begin
            tag_vld_q[0] <= xfer;
            tag_id_q[0]  <= xfer_id;
            for (int i = 1; i < NORM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign tag_exit = tag_vld_q[NORM_LATENCY-1];

    // In-flight count: issue adds one, tag exit removes one, both together cancel
    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, tag_exit})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // In-flight counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign push_data.id       = tag_id_q[NORM_LATENCY-1];
    assign push_data.sign     = n_sign;
    assign push_data.exponent = n_exponent;
    assign push_data.mantissa = n_mantissa;

    assign fifo_pop = res_valid && res_ready;

    fpu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tag_exit),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign res_valid    = !fifo_empty;
    assign res_id       = head.id;
    assign res_sign     = head.sign;
    assign res_exponent = head.exponent;
    assign res_mantissa = head.mantissa;

    assign busy = (inflight_q != '0) || (fifo_count != '0);

    // A result emerging into a full FIFO means the credit accounting is broken
    assert property (@(posedge clk) disable iff (rst) !(tag_exit && fifo_full));

endmodule
